// File: rtl/dvs_event_bus_buffer_pkg.sv
// dvs_ravens_pkg: shared event width, buffer defaults and the bus-buffer state type
package dvs_ravens_pkg;
  localparam int EVENT_BITS = 32;
  localparam int DVS_EVT_BUF_DEPTH = 8;
  localparam int DVS_EVT_BUF_MAX_BURST = 4;
  typedef enum logic [1:0] {IDLE, REQ, XFER, YIELD} bus_buf_state_t;
endpackage

// File: rtl/dvs_event_bus_buffer_if.sv
// dvs_event_bus_buffer_if: event-input and shared-bus handshake bundle
//   in_event/in_valid/in_filtered : preprocessor side
//   fifo_grant/fifo_req/fifo_bus_valid : arbiter handshake and data strobe
//   slave = buffer side, master = preprocessor/arbiter side
interface dvs_event_bus_buffer_if import dvs_ravens_pkg::*; ();
  logic [EVENT_BITS-1:0] in_event;
  logic in_valid;
  logic in_filtered;
  logic fifo_grant;
  logic fifo_req;
  logic fifo_bus_valid;
  modport slave (input in_event, in_valid, in_filtered, fifo_grant, output fifo_req, fifo_bus_valid);
  modport master (output in_event, in_valid, in_filtered, fifo_grant, input fifo_req, fifo_bus_valid);
endinterface

// File: rtl/dvs_event_sync_fifo.sv
// dvs_event_sync_fifo: circular event store with occupancy-based full/empty
//   wr_en_i/wr_data_i : write port (caller guarantees room)
//   rd_en_i/rd_data_o : read port, rd_data_o is the current head word
//   occupancy_o/full_o/empty_o : fill status
module dvs_event_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int W = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en_i,
  input  logic [W-1:0]             wr_data_i,
  input  logic                     rd_en_i,
  output logic [W-1:0]             rd_data_o,
  output logic [$clog2(DEPTH):0]   occupancy_o,
  output logic                     full_o,
  output logic                     empty_o
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0] occ_q;
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[wr_ptr_q] <= wr_data_i;
  end
  // pointers wrap naturally at DEPTH since DEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_en_i ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q <= rd_en_i ? rd_ptr_q + 1'b1 : rd_ptr_q;
      occ_q    <= occ_q + (AW+1)'(wr_en_i) - (AW+1)'(rd_en_i);
    end
  end
  assign rd_data_o   = mem_q[rd_ptr_q];
  assign occupancy_o = occ_q;
  assign full_o      = occ_q == (AW+1)'(DEPTH);
  assign empty_o     = occ_q == '0;
endmodule

// File: rtl/dvs_event_bus_buffer.sv
// dvs_event_bus_buffer: queues DVS events and drains them onto the shared bus in bounded bursts
//   clk, rst_n      : clock, async active-low reset
//   bus (slave)     : event input and arbiter req/grant/valid handshake
//   fifo_bus_event  : tri-stated bus data, driven only the cycle after a pop
//   occupancy       : stored event count
//   overflow        : one-cycle pulse per dropped event
//   drop_count      : saturating dropped-event count, only with DVS_EVENT_BUS_DROP_COUNTER_EN
module dvs_event_bus_buffer import dvs_ravens_pkg::*; #(
  parameter int DEPTH = DVS_EVT_BUF_DEPTH,
  parameter int MAX_BURST = DVS_EVT_BUF_MAX_BURST,
  parameter int DROP_CNT_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  dvs_event_bus_buffer_if.slave       bus,
  output logic [EVENT_BITS-1:0]       fifo_bus_event,
  output logic [$clog2(DEPTH):0]      occupancy,
  output logic                        overflow
`ifdef DVS_EVENT_BUS_DROP_COUNTER_EN
  ,
  output logic [DROP_CNT_BITS-1:0]    drop_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int BW = $clog2(MAX_BURST + 1);
  bus_buf_state_t state_q, state_d;
  logic [BW-1:0] burst_q, burst_d, burst_inc;
  logic [EVENT_BITS-1:0] head, bus_data_q, bus_data_d;
  logic bus_valid_q, overflow_q, overflow_d;
  logic push, push_ok, pop, full, empty;
  logic [AW:0] occ_next;
  dvs_event_sync_fifo #(.DEPTH(DEPTH), .W(EVENT_BITS)) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en_i     (push_ok),
    .wr_data_i   (bus.in_event),
    .rd_en_i     (pop),
    .rd_data_o   (head),
    .occupancy_o (occupancy),
    .full_o      (full),
    .empty_o     (empty)
  );
  assign push = bus.in_valid && !bus.in_filtered;
  // a full buffer still accepts when the same edge frees a slot
  assign push_ok = push && (!full || pop);
  assign pop = state_q == XFER && bus.fifo_grant && !empty;
  assign occ_next = occupancy + (AW+1)'(push_ok) - (AW+1)'(pop);
  assign burst_inc = burst_q + BW'(pop);
  assign overflow_d = push && !push_ok;
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = empty ? IDLE : REQ;
      REQ:     state_d = bus.fifo_grant ? XFER : REQ;
      XFER:    state_d = (!bus.fifo_grant || burst_inc == BW'(MAX_BURST) || occ_next == '0) ? YIELD : XFER;
      default: state_d = IDLE;
    endcase
    burst_d = state_d == YIELD ? '0 : burst_inc;
    bus_data_d = pop ? head : bus_data_q;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      burst_q     <= '0;
      bus_valid_q <= 1'b0;
      bus_data_q  <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      burst_q     <= burst_d;
      bus_valid_q <= pop;
      bus_data_q  <= bus_data_d;
      overflow_q  <= overflow_d;
    end
  end
`ifdef DVS_EVENT_BUS_DROP_COUNTER_EN
  logic [DROP_CNT_BITS-1:0] drop_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) drop_q <= '0;
    else drop_q <= (overflow_d && ~&drop_q) ? drop_q + 1'b1 : drop_q;
  end
  assign drop_count = drop_q;
`endif
  assign bus.fifo_req = state_q == REQ || state_q == XFER;
  assign bus.fifo_bus_valid = bus_valid_q;
  assign fifo_bus_event = bus_valid_q ? bus_data_q : 'z;
  assign overflow = overflow_q;
endmodule

// File: tb/tb_dvs_event_bus_buffer.sv
// tb_dvs_event_bus_buffer: directed table plus multi-cycle sequences for the event bus buffer
module tb_dvs_event_bus_buffer;
  import dvs_ravens_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  dvs_event_bus_buffer_if bus();
  wire [EVENT_BITS-1:0] bus_event;
  logic [3:0] occupancy;
  logic overflow;
`ifdef DVS_EVENT_BUS_DROP_COUNTER_EN
  logic [15:0] drop_count;
`endif
  dvs_event_bus_buffer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .fifo_bus_event (bus_event),
    .occupancy      (occupancy),
    .overflow       (overflow)
`ifdef DVS_EVENT_BUS_DROP_COUNTER_EN
    ,
    .drop_count     (drop_count)
`endif
  );
  int errors = 0;
  int checks = 0;
  logic [31:0] got[$];
  int ovf_pulses = 0;
  int run = 0;
  int max_run = 0;
  always @(negedge clk) begin
    if (bus.fifo_bus_valid) begin
      got.push_back(bus_event);
      run = run + 1;
      if (run > max_run) max_run = run;
    end else run = 0;
    if (overflow) ovf_pulses = ovf_pulses + 1;
  end
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    #1;
  endtask
  task automatic push(input logic [31:0] d, input logic f);
    bus.in_valid = 1'b1;
    bus.in_filtered = f;
    bus.in_event = d;
    step();
    bus.in_valid = 1'b0;
    bus.in_filtered = 1'b0;
  endtask
  task automatic drain(input int n, input string name);
    bus.fifo_grant = 1'b1;
    for (int i = 0; i < 300 && got.size() < n; i++) step();
    for (int i = 0; i < 6; i++) step();
    check(name, 32'(got.size()), 32'(n));
    bus.fifo_grant = 1'b0;
  endtask
  typedef struct {
    logic v, f, g;
    logic [31:0] d;
    logic [3:0] occ;
    logic req, bv, ovf;
    logic [31:0] ev;
  } vec_t;
  vec_t tbl[7];
  initial begin
    tbl[0] = '{1'b1, 1'b1, 1'b1, 32'h11, 4'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[1] = '{1'b1, 1'b0, 1'b1, 32'hA5, 4'd1, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[2] = '{1'b0, 1'b0, 1'b1, 32'h0,  4'd1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[3] = '{1'b0, 1'b0, 1'b1, 32'h0,  4'd1, 1'b1, 1'b0, 1'b0, 32'h0};
    tbl[4] = '{1'b0, 1'b0, 1'b1, 32'h0,  4'd0, 1'b0, 1'b1, 1'b0, 32'hA5};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 32'h0,  4'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    tbl[6] = '{1'b0, 1'b0, 1'b1, 32'h0,  4'd0, 1'b0, 1'b0, 1'b0, 32'h0};
    bus.in_event = '0;
    bus.in_valid = 1'b0;
    bus.in_filtered = 1'b0;
    bus.fifo_grant = 1'b0;
    #1;
    check("reset_occ", 32'(occupancy), 0);
    check("reset_req", 32'(bus.fifo_req), 0);
    check("reset_valid", 32'(bus.fifo_bus_valid), 0);
    check("reset_ovf", 32'(overflow), 0);
`ifdef DVS_EVENT_BUS_DROP_COUNTER_EN
    check("reset_drop", 32'(drop_count), 0);
`endif
    step();
    step();
    rst_n = 1'b1;
    step();
    for (int i = 0; i < 7; i++) begin
      bus.in_valid = tbl[i].v;
      bus.in_filtered = tbl[i].f;
      bus.fifo_grant = tbl[i].g;
      bus.in_event = tbl[i].d;
      step();
      check($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
      check($sformatf("tbl%0d_req", i), 32'(bus.fifo_req), 32'(tbl[i].req));
      check($sformatf("tbl%0d_valid", i), 32'(bus.fifo_bus_valid), 32'(tbl[i].bv));
      check($sformatf("tbl%0d_ovf", i), 32'(overflow), 32'(tbl[i].ovf));
      if (tbl[i].bv) check($sformatf("tbl%0d_event", i), bus_event, tbl[i].ev);
    end
    bus.in_valid = 1'b0;
    got.delete();
    max_run = 0;
    bus.fifo_grant = 1'b1;
    for (int i = 0; i < 6; i++) push(32'h100 + 32'(i), 1'b0);
    drain(6, "burst_count");
    for (int i = 0; i < 6 && i < got.size(); i++) check($sformatf("burst_word%0d", i), got[i], 32'h100 + 32'(i));
    check("burst_max_run", 32'(max_run), 4);
    check("burst_occ_end", 32'(occupancy), 0);
    got.delete();
    ovf_pulses = 0;
    for (int i = 0; i < 9; i++) push(32'h200 + 32'(i), 1'b0);
    step();
    check("ovf_occ", 32'(occupancy), 8);
    check("ovf_pulses", 32'(ovf_pulses), 1);
`ifdef DVS_EVENT_BUS_DROP_COUNTER_EN
    check("ovf_drop_count", 32'(drop_count), 1);
`endif
    drain(8, "ovf_drain_count");
    for (int i = 0; i < 8 && i < got.size(); i++) check($sformatf("ovf_word%0d", i), got[i], 32'h200 + 32'(i));
    got.delete();
    ovf_pulses = 0;
    for (int i = 0; i < 8; i++) push(32'h300 + 32'(i), 1'b0);
    check("full_occ_before", 32'(occupancy), 8);
    bus.fifo_grant = 1'b1;
    step();
    push(32'h3FF, 1'b0);
    check("full_pp_occ", 32'(occupancy), 8);
    check("full_pp_ovf", 32'(overflow), 0);
    check("full_pp_valid", 32'(bus.fifo_bus_valid), 1);
    check("full_pp_event", bus_event, 32'h300);
    drain(9, "full_drain_count");
    if (got.size() == 9) check("full_last_word", got[8], 32'h3FF);
    check("full_no_ovf", 32'(ovf_pulses), 0);
    got.delete();
    for (int i = 0; i < 5; i++) push(32'h400 + 32'(i), (i == 0 || i == 2 || i == 3));
    check("filt_occ", 32'(occupancy), 2);
    drain(2, "filt_drain_count");
    if (got.size() == 2) begin
      check("filt_word0", got[0], 32'h401);
      check("filt_word1", got[1], 32'h404);
    end
    got.delete();
    for (int i = 0; i < 4; i++) push(32'h500 + 32'(i), 1'b0);
    bus.fifo_grant = 1'b1;
    step();
    step();
    step();
    bus.fifo_grant = 1'b0;
    check("hold_got_two", 32'(got.size()), 2);
    for (int i = 0; i < 4; i++) step();
    check("hold_occ", 32'(occupancy), 2);
    check("hold_got_still_two", 32'(got.size()), 2);
    check("hold_valid", 32'(bus.fifo_bus_valid), 0);
    bus.fifo_grant = 1'b1;
    for (int i = 0; i < 10 && !bus.fifo_bus_valid; i++) step();
    check("resume_valid", 32'(bus.fifo_bus_valid), 1);
    check("resume_event", bus_event, 32'h502);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_occ", 32'(occupancy), 0);
    check("midrst_req", 32'(bus.fifo_req), 0);
    check("midrst_valid", 32'(bus.fifo_bus_valid), 0);
    check("midrst_ovf", 32'(overflow), 0);
`ifdef DVS_EVENT_BUS_DROP_COUNTER_EN
    check("midrst_drop", 32'(drop_count), 0);
`endif
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) step();
    check("postrst_got", 32'(got.size()), 3);
    check("postrst_occ", 32'(occupancy), 0);
    check("postrst_req", 32'(bus.fifo_req), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
